count_sequencer: RTL and testbench



---
 rtl/count_sequencer_pkg.sv | 17 +
 rtl/count_sequencer_dp.sv | 29 ++
 rtl/count_sequencer.sv | 133 +++++++++++++
 tb/tb_count_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/count_sequencer_pkg.sv
// Shared types and constants for the count sequencer and its counter datapath.
package count_sequencer_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int REP_W_DEF = 8;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/count_sequencer_dp.sv
// Loadable wrap-around up/down counter; load wins over enable.
module updown_counter_dp
  import count_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             dir,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Counter register: natural modulo-2^WIDTH arithmetic gives the wrap both ways.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= (dir == DIR_UP) ? cnt + ONE : cnt - ONE;
    end
  end

endmodule

// File: rtl/count_sequencer.sv
// Job controller: accepts a count job, drives the counter datapath, reports
// terminal counts, repeats periods and signals completion or cancellation.
module count_sequencer
  import count_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int REP_W = REP_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_start,
  input  logic [WIDTH-1:0] cfg_end,
  input  logic             cfg_dir,
  input  logic [REP_W-1:0] cfg_reps,
  input  logic             step_en,
  input  logic             abort,
  output logic [WIDTH-1:0] cnt_out,
  output logic             busy,
  output logic             tick,
  output logic             done,
  output logic             aborted
);

  localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] start_q;
  logic [WIDTH-1:0] end_q;
  logic             dir_q;
  logic [REP_W-1:0] rem;
  logic             at_end;
  logic             accept;
  logic             cnt_load;
  logic             cnt_en;
  logic             reload;

  assign at_end = (cnt_out == end_q);
  assign accept = (state == IDLE) && cfg_valid;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; abort from any active state returns straight to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cfg_valid) state_next = LOAD;
      LOAD:    state_next = abort ? IDLE : RUN;
      RUN: begin
        if (abort)                       state_next = IDLE;
        else if (at_end && (rem == '0))  state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output and datapath control decode; abort masks tick, reload and done.
  always_comb begin
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    reload    = 1'b0;
    tick      = 1'b0;
    done      = 1'b0;
    aborted   = 1'b0;
    busy      = (state != IDLE);
    cfg_ready = (state == IDLE);
    case (state)
      LOAD: begin
        if (abort) aborted  = 1'b1;
        else       cnt_load = 1'b1;
      end
      RUN: begin
        if (abort) begin
          aborted = 1'b1;
        end else if (at_end) begin
          tick     = 1'b1;
          reload   = (rem != '0);
          cnt_load = (rem != '0);
        end else begin
          cnt_en = step_en;
        end
      end
      DONE: begin
        if (abort) aborted = 1'b1;
        else       done    = 1'b1;
      end
      default: ;
    endcase
  end

  // Remaining-period counter: loaded on handshake, decremented on each reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem <= '0;
    end else if (accept) begin
      rem <= cfg_reps;
    end else if (reload) begin
      rem <= rem - REP_ONE;
    end
  end

  // Job parameters captured only on handshake; later cfg changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      start_q <= cfg_start;
      end_q   <= cfg_end;
      dir_q   <= cfg_dir;
    end
  end

  updown_counter_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (start_q),
    .en       (cnt_en),
    .dir      (dir_q),
    .cnt      (cnt_out)
  );

endmodule

// File: tb/tb_count_sequencer.sv
// Directed, table-driven bench for count_sequencer (WIDTH=4, REP_W=8).
module tb_count_sequencer;

  logic       clk;
  logic       rst_n;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [3:0] cfg_start;
  logic [3:0] cfg_end;
  logic       cfg_dir;
  logic [7:0] cfg_reps;
  logic       step_en;
  logic       abort;
  logic [3:0] cnt_out;
  logic       busy;
  logic       tick;
  logic       done;
  logic       aborted;

  int n_cmp = 0;
  int n_bad = 0;

  count_sequencer #(.WIDTH(4), .REP_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_start (cfg_start),
    .cfg_end   (cfg_end),
    .cfg_dir   (cfg_dir),
    .cfg_reps  (cfg_reps),
    .step_en   (step_en),
    .abort     (abort),
    .cnt_out   (cnt_out),
    .busy      (busy),
    .tick      (tick),
    .done      (done),
    .aborted   (aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [3:0] s;
    logic [3:0] e;
    logic       d;
    logic [7:0] r;
    logic       st;
    logic       ab;
    logic [3:0] ecnt;
    logic       ebusy;
    logic       erdy;
    logic       etick;
    logic       edone;
    logic       eab;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic v, input logic [3:0] s, input logic [3:0] e,
                              input logic d, input logic [7:0] r, input logic st,
                              input logic ab, input logic [3:0] ecnt, input logic ebusy,
                              input logic erdy, input logic etick, input logic edone,
                              input logic eab);
    vec_t x;
    x.v = v; x.s = s; x.e = e; x.d = d; x.r = r; x.st = st; x.ab = ab;
    x.ecnt = ecnt; x.ebusy = ebusy; x.erdy = erdy;
    x.etick = etick; x.edone = edone; x.eab = eab;
    return x;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int ecnt, input int ebusy, input int erdy,
                           input int etick, input int edone, input int eab);
    chk({tag, " cnt_out"},   int'(cnt_out),   ecnt);
    chk({tag, " busy"},      int'(busy),      ebusy);
    chk({tag, " cfg_ready"}, int'(cfg_ready), erdy);
    chk({tag, " tick"},      int'(tick),      etick);
    chk({tag, " done"},      int'(done),      edone);
    chk({tag, " aborted"},   int'(aborted),   eab);
  endtask

  task automatic drive(input logic v, input logic [3:0] s, input logic [3:0] e,
                       input logic d, input logic [7:0] r, input logic st, input logic ab);
    cfg_valid = v; cfg_start = s; cfg_end = e; cfg_dir = d;
    cfg_reps = r; step_en = st; abort = ab;
  endtask

  // One cycle: drive just after the rising edge, compare on the falling edge.
  task automatic run_cycle(input string tag, input logic v, input logic [3:0] s,
                           input logic [3:0] e, input logic d, input logic [7:0] r,
                           input logic st, input logic ab, input int ecnt, input int ebusy,
                           input int erdy, input int etick, input int edone, input int eab);
    @(posedge clk); #1;
    drive(v, s, e, d, r, st, ab);
    @(negedge clk);
    check_all(tag, ecnt, ebusy, erdy, etick, edone, eab);
  endtask

  initial begin
    // Job A: up 2->5, single period; cfg_valid held through DONE is not taken.
    vecs.push_back(mk(1, 2,  5, 1, 0, 1, 0,  0, 0, 1, 0, 0, 0)); // c0 handshake
    vecs.push_back(mk(0, 0,  0, 0, 0, 1, 0,  0, 1, 0, 0, 0, 0)); // c1 LOAD
    vecs.push_back(mk(0, 0,  0, 0, 0, 1, 0,  2, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0, 0, 0, 1, 0,  3, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0, 0, 0, 1, 0,  4, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0, 0, 0, 1, 0,  5, 1, 0, 1, 0, 0)); // c5 tick
    vecs.push_back(mk(1, 9,  9, 1, 3, 1, 0,  5, 1, 0, 0, 1, 0)); // c6 DONE, valid ignored
    // Job B: down 1->14 through the wrap.
    vecs.push_back(mk(1, 1, 14, 0, 0, 1, 0,  5, 0, 1, 0, 0, 0)); // c7 handshake
    vecs.push_back(mk(0, 0,  0, 0, 0, 1, 0,  5, 1, 0, 0, 0, 0)); // LOAD
    vecs.push_back(mk(0, 0,  0, 0, 0, 1, 0,  1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0, 0, 0, 1, 0,  0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0, 0, 0, 1, 0, 15, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0, 0, 0, 1, 0, 14, 1, 0, 1, 0, 0)); // tick
    vecs.push_back(mk(0, 0,  0, 0, 0, 1, 0, 14, 1, 0, 0, 1, 0)); // done
    // Job C: up 0->3, three periods.
    vecs.push_back(mk(1, 0,  3, 1, 2, 1, 0, 14, 0, 1, 0, 0, 0)); // handshake
    vecs.push_back(mk(0, 0,  0, 0, 0, 1, 0, 14, 1, 0, 0, 0, 0)); // LOAD
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 4; k++) begin
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 4'(k), 1, 0, (k == 3) ? 1'b1 : 1'b0, 0, 0));
      end
    end
    vecs.push_back(mk(0, 0,  0, 0, 0, 1, 0,  3, 1, 0, 0, 1, 0)); // single done
    // Job D: up 0->5 with a 3-cycle pause at 3, paused on the terminal count.
    vecs.push_back(mk(1, 0,  5, 1, 0, 1, 0,  3, 0, 1, 0, 0, 0)); // handshake
    vecs.push_back(mk(0, 0,  0, 0, 0, 1, 0,  3, 1, 0, 0, 0, 0)); // LOAD
    vecs.push_back(mk(0, 0,  0, 0, 0, 1, 0,  0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0, 0, 0, 1, 0,  1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0, 0, 0, 1, 0,  2, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0, 0, 0, 0, 0,  3, 1, 0, 0, 0, 0)); // pause 1
    vecs.push_back(mk(0, 0,  0, 0, 0, 0, 0,  3, 1, 0, 0, 0, 0)); // pause 2
    vecs.push_back(mk(0, 0,  0, 0, 0, 0, 0,  3, 1, 0, 0, 0, 0)); // pause 3
    vecs.push_back(mk(0, 0,  0, 0, 0, 1, 0,  3, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0, 0, 0, 1, 0,  4, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0, 0, 0, 0, 0,  5, 1, 0, 1, 0, 0)); // tick while paused
    vecs.push_back(mk(0, 0,  0, 0, 0, 1, 0,  5, 1, 0, 0, 1, 0)); // done
    // Job E: abort mid-count at 4.
    vecs.push_back(mk(1, 2,  9, 1, 0, 1, 0,  5, 0, 1, 0, 0, 0)); // handshake
    vecs.push_back(mk(0, 0,  0, 0, 0, 1, 0,  5, 1, 0, 0, 0, 0)); // LOAD
    vecs.push_back(mk(0, 0,  0, 0, 0, 1, 0,  2, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0, 0, 0, 1, 0,  3, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0, 0, 0, 1, 1,  4, 1, 0, 0, 0, 1)); // abort
    // Job F: abort coincident with terminal count, repeats pending.
    vecs.push_back(mk(1, 6,  7, 1, 1, 1, 0,  4, 0, 1, 0, 0, 0)); // handshake, cnt held at 4
    vecs.push_back(mk(0, 0,  0, 0, 0, 1, 0,  4, 1, 0, 0, 0, 0)); // LOAD
    vecs.push_back(mk(0, 0,  0, 0, 0, 1, 0,  6, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0, 0, 0, 1, 1,  7, 1, 0, 0, 0, 1)); // abort beats tick
    vecs.push_back(mk(0, 0,  0, 0, 0, 1, 1,  7, 0, 1, 0, 0, 0)); // abort in IDLE ignored
    vecs.push_back(mk(0, 0,  0, 0, 0, 1, 0,  7, 0, 1, 0, 0, 0));

    // Reset state.
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset cnt_out", int'(cnt_out), 0);
    chk("reset busy",    int'(busy),    0);
    chk("reset tick",    int'(tick),    0);
    chk("reset done",    int'(done),    0);
    chk("reset aborted", int'(aborted), 0);
    #2 rst_n = 1'b1;
    #1 chk("post-reset cfg_ready", int'(cfg_ready), 1);

    foreach (vecs[i]) begin
      run_cycle($sformatf("v%0d", i), vecs[i].v, vecs[i].s, vecs[i].e, vecs[i].d, vecs[i].r,
                vecs[i].st, vecs[i].ab, vecs[i].ecnt, vecs[i].ebusy, vecs[i].erdy,
                vecs[i].etick, vecs[i].edone, vecs[i].eab);
    end

    // Asynchronous reset mid-RUN, asserted and released between clock edges.
    run_cycle("rg hs",   1, 0, 9, 1, 0, 1, 0,  7, 0, 1, 0, 0, 0);
    run_cycle("rg load", 0, 0, 0, 0, 0, 1, 0,  7, 1, 0, 0, 0, 0);
    run_cycle("rg r0",   0, 0, 0, 0, 0, 1, 0,  0, 1, 0, 0, 0, 0);
    run_cycle("rg r1",   0, 0, 0, 0, 0, 1, 0,  1, 1, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("rg pre cnt_out", int'(cnt_out), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("rg async cnt_out", int'(cnt_out), 0);
    chk("rg async busy",    int'(busy),    0);
    chk("rg async tick",    int'(tick),    0);
    chk("rg async done",    int'(done),    0);
    chk("rg async aborted", int'(aborted), 0);
    @(posedge clk); #2 rst_n = 1'b1;
    #1;
    chk("rg release cfg_ready", int'(cfg_ready), 1);
    chk("rg release busy",      int'(busy),      0);
    // start == end: tick on the first RUN cycle, done right after.
    run_cycle("eq hs",   1, 7, 7, 1, 0, 1, 0,  0, 0, 1, 0, 0, 0);
    run_cycle("eq load", 0, 0, 0, 0, 0, 1, 0,  0, 1, 0, 0, 0, 0);
    run_cycle("eq run",  0, 0, 0, 0, 0, 1, 0,  7, 1, 0, 1, 0, 0);
    run_cycle("eq done", 0, 0, 0, 0, 0, 1, 0,  7, 1, 0, 0, 1, 0);
    run_cycle("eq idle", 0, 0, 0, 0, 0, 1, 0,  7, 0, 1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
